// File: rtl/sa_ram_rd_burst_64x129.sv
// Read-side burst controller for the 64x129 two-stage-read SRAM.
// Issues a wrapping address stream and returns beats over valid/ready.
module sa_ram_rd_burst_64x129 (
    input  logic         nvdla_core_clk,
    input  logic         nvdla_core_rstn,
    input  logic         cmd_pvld,
    output logic         cmd_prdy,
    input  logic [5:0]   cmd_addr,
    input  logic [5:0]   cmd_len,
    output logic [5:0]   ram_ra,
    output logic         ram_re,
    output logic         ram_ore,
    input  logic [128:0] ram_dout,
    output logic         rsp_pvld,
    input  logic         rsp_prdy,
    output logic [128:0] rsp_pd,
    output logic         rsp_last,
    output logic         rd_busy
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t     state;
    logic [5:0] cur_addr;
    logic [5:0] rem;
    logic       v1;
    logic       l1;
    logic       v2;
    logic       l2;
    logic       run;
    logic       adv1;

    assign run      = (state == RUN);
    assign ram_ore  = v1 && (!v2 || rsp_prdy);
    assign adv1     = !v1 || ram_ore;
    assign ram_re   = run && adv1;
    assign ram_ra   = cur_addr;
    assign cmd_prdy = !run;
    assign rsp_pvld = v2;
    assign rsp_last = l2;
    assign rsp_pd   = ram_dout;
    assign rd_busy  = run || v1 || v2;

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state    <= IDLE;
            cur_addr <= 6'd0;
            rem      <= 6'd0;
            v1       <= 1'b0;
            l1       <= 1'b0;
            v2       <= 1'b0;
            l2       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cmd_pvld) begin
                        cur_addr <= cmd_addr;
                        rem      <= cmd_len;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (ram_re) begin
                        cur_addr <= cur_addr + 6'd1;
                        rem      <= rem - 6'd1;
                        if (rem == 6'd0)
                            state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Stage 1 mirrors the RAM address register.
            if (ram_re) begin
                v1 <= 1'b1;
                l1 <= (rem == 6'd0);
            end else if (ram_ore) begin
                v1 <= 1'b0;
            end

            // Stage 2 mirrors the RAM output register.
            if (ram_ore) begin
                v2 <= 1'b1;
                l2 <= l1;
            end else if (v2 && rsp_prdy) begin
                v2 <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sa_ram_rd_burst_64x129.sv
// Bench for sa_ram_rd_burst_64x129: behavioural RAM, expected-beat
// queue built from each accepted command, plus directed literal checks.
module tb_sa_ram_rd_burst_64x129;

    logic         clk = 1'b0;
    logic         rstn;
    logic         cmd_pvld;
    logic         cmd_prdy;
    logic [5:0]   cmd_addr;
    logic [5:0]   cmd_len;
    logic [5:0]   ram_ra;
    logic         ram_re;
    logic         ram_ore;
    logic [128:0] ram_dout;
    logic         rsp_pvld;
    logic         rsp_prdy;
    logic [128:0] rsp_pd;
    logic         rsp_last;
    logic         rd_busy;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic [128:0] mem [64];
    logic [5:0]   ra_q;
    logic [128:0] dout_q;

    logic [128:0] exp_d [$];
    logic         exp_l [$];
    logic [128:0] log_d [$];
    logic         log_l [$];
    int           log_c [$];

    logic         prev_stall;
    logic [128:0] prev_pd;

    sa_ram_rd_burst_64x129 dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .cmd_pvld        (cmd_pvld),
        .cmd_prdy        (cmd_prdy),
        .cmd_addr        (cmd_addr),
        .cmd_len         (cmd_len),
        .ram_ra          (ram_ra),
        .ram_re          (ram_re),
        .ram_ore         (ram_ore),
        .ram_dout        (ram_dout),
        .rsp_pvld        (rsp_pvld),
        .rsp_prdy        (rsp_prdy),
        .rsp_pd          (rsp_pd),
        .rsp_last        (rsp_last),
        .rd_busy         (rd_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Two-stage-read RAM: address latch on re, output register on ore.
    always @(posedge clk) begin
        if (ram_re) ra_q <= ram_ra;
        if (ram_ore) dout_q <= mem[ra_q];
    end
    assign ram_dout = dout_q;

    task automatic chk(input string nm, input logic [128:0] act,
                       input logic [128:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard and response monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rstn) begin
            exp_d.delete();
            exp_l.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_pvld", {128'd0, rsp_pvld}, 129'd1);
                chk("hold_pd", rsp_pd, prev_pd);
            end
            if (rsp_pvld) begin
                if (exp_d.size() == 0) begin
                    chk("unexpected_beat", {128'd0, rsp_pvld}, 129'd0);
                end else begin
                    chk("beat_data", rsp_pd, exp_d[0]);
                    chk("beat_last", {128'd0, rsp_last},
                        {128'd0, exp_l[0]});
                    if (rsp_prdy) begin
                        log_d.push_back(rsp_pd);
                        log_l.push_back(rsp_last);
                        log_c.push_back(cyc);
                        void'(exp_d.pop_front());
                        void'(exp_l.pop_front());
                    end
                end
            end
            prev_stall = rsp_pvld && !rsp_prdy;
            prev_pd    = rsp_pd;
            if (cmd_pvld && cmd_prdy) begin
                for (int i = 0; i <= int'(cmd_len); i++) begin
                    exp_d.push_back(mem[(int'(cmd_addr) + i) % 64]);
                    exp_l.push_back(i == int'(cmd_len));
                end
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_beats(input int n, input string nm);
        int k;
        k = 0;
        while (log_d.size() < n && k < 400) begin
            step();
            k++;
        end
        @(negedge clk);
        chk(nm, 129'(log_d.size() >= n), 129'd1);
    endtask

    initial begin
        int c0;
        int n0;
        int hs;
        logic [15:0] lfsr;

        rstn     = 1'b0;
        cmd_pvld = 1'b0;
        cmd_addr = 6'd0;
        cmd_len  = 6'd0;
        rsp_prdy = 1'b1;
        for (int i = 0; i < 64; i++) mem[i] = 129'(i);
        mem[5] = 129'h1_0000_0000_0000_0000_0000_0000_0000_00AB;

        #3;
        chk("rst_prdy", {128'd0, cmd_prdy}, 129'd1);
        chk("rst_re", {128'd0, ram_re}, 129'd0);
        chk("rst_ra", {123'd0, ram_ra}, 129'd0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        step();
        @(negedge clk);
        chk("idle_prdy", {128'd0, cmd_prdy}, 129'd1);
        chk("idle_busy", {128'd0, rd_busy}, 129'd0);
        chk("idle_outs", {126'd0, ram_re, ram_ore, rsp_pvld}, 129'd0);

        // Single beat from address 5.
        step();
        cmd_pvld = 1'b1; cmd_addr = 6'd5; cmd_len = 6'd0;
        step();
        cmd_pvld = 1'b0;
        @(negedge clk);
        chk("c1_re", {128'd0, ram_re}, 129'd1);
        chk("c1_ra", {123'd0, ram_ra}, 129'd5);
        step();
        @(negedge clk);
        chk("c2_ore", {128'd0, ram_ore}, 129'd1);
        step();
        @(negedge clk);
        chk("c3_pvld_last", {127'd0, rsp_pvld, rsp_last}, 129'd3);
        chk("c3_pd", rsp_pd, 129'h1_0000_0000_0000_0000_0000_0000_0000_00AB);
        step();
        @(negedge clk);
        chk("c4_busy", {128'd0, rd_busy}, 129'd0);

        // Wrapping burst 62,63,0,1.
        for (int i = 0; i < 64; i++) mem[i] = 129'(i);
        n0 = log_d.size();
        step();
        cmd_pvld = 1'b1; cmd_addr = 6'd62; cmd_len = 6'd3;
        c0 = cyc;
        step();
        cmd_pvld = 1'b0;
        wait_beats(n0 + 4, "wrap_done");
        if (log_d.size() >= n0 + 4) begin
            chk("wrap_b0", log_d[n0], 129'd62);
            chk("wrap_b1", log_d[n0+1], 129'd63);
            chk("wrap_b2", log_d[n0+2], 129'd0);
            chk("wrap_b3", log_d[n0+3], 129'd1);
            chk("wrap_lasts", {125'd0, log_l[n0], log_l[n0+1],
                log_l[n0+2], log_l[n0+3]}, 129'd1);
            chk("wrap_first_cyc", 129'(log_c[n0] - c0), 129'd3);
            chk("wrap_last_cyc", 129'(log_c[n0+3] - c0), 129'd6);
        end

        // 64-beat burst under LFSR backpressure.
        repeat (3) step();
        n0 = log_d.size();
        lfsr = 16'hACE1;
        cmd_pvld = 1'b1; cmd_addr = 6'd0; cmd_len = 6'd63;
        step();
        cmd_pvld = 1'b0;
        for (int k = 0; k < 600 && log_d.size() < n0 + 64; k++) begin
            rsp_prdy = lfsr[0];
            lfsr = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
            step();
        end
        rsp_prdy = 1'b1;
        @(negedge clk);
        chk("bp_count", 129'(log_d.size() - n0), 129'd64);
        if (log_d.size() >= n0 + 64) begin
            for (int i = 0; i < 64; i++) begin
                chk("bp_order", log_d[n0+i], 129'(i));
                chk("bp_last", {128'd0, log_l[n0+i]}, 129'(i == 63));
            end
        end

        // Back-to-back commands with valid held.
        repeat (3) step();
        n0 = log_d.size();
        cmd_pvld = 1'b1; cmd_addr = 6'd10; cmd_len = 6'd1;
        c0 = cyc;
        step();
        cmd_addr = 6'd20; cmd_len = 6'd0;
        hs = -1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (cmd_prdy) begin
                hs = cyc;
                break;
            end
            step();
        end
        step();
        cmd_pvld = 1'b0;
        chk("b2b_accept", 129'(hs - c0), 129'd3);
        wait_beats(n0 + 3, "b2b_done");
        if (log_d.size() >= n0 + 3) begin
            chk("b2b_d0", log_d[n0], 129'd10);
            chk("b2b_d1", log_d[n0+1], 129'd11);
            chk("b2b_d2", log_d[n0+2], 129'd20);
            chk("b2b_lasts", {126'd0, log_l[n0], log_l[n0+1],
                log_l[n0+2]}, 129'd3);
        end

        // Reset in c4 of a 16-beat burst.
        repeat (3) step();
        cmd_pvld = 1'b1; cmd_addr = 6'd0; cmd_len = 6'd15;
        step();
        cmd_pvld = 1'b0;
        repeat (3) step();
        #1 rstn = 1'b0;
        #1;
        chk("mid_rst_pvld", {128'd0, rsp_pvld}, 129'd0);
        chk("mid_rst_busy", {128'd0, rd_busy}, 129'd0);
        step();
        rstn = 1'b1;
        step();
        @(negedge clk);
        chk("post_rst_prdy", {128'd0, cmd_prdy}, 129'd1);
        for (int k = 0; k < 6; k++) begin
            step();
            @(negedge clk);
            chk("post_rst_quiet", {128'd0, rsp_pvld}, 129'd0);
        end
        chk("sb_empty", 129'(exp_d.size()), 129'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sa_ram_rd_burst_64x129.md
# sa_ram_rd_burst_64x129

Read-side burst controller for the 64x129 two-stage-read SRAM (`sa_ram_rwsp_64x129`). It accepts a burst command (start address plus beat count) through a valid/ready handshake and generates a wrapping address stream on the RAM read port (`ra`/`re`). It manages the RAM's output-register enable (`ore`) and returns read data to a consumer through a valid/ready response channel, with full backpressure and one beat per cycle sustained. It sits between the RAM instance and any engine draining that RAM; the write side is driven by a separate block.

## Interface
- No parameters; geometry is fixed: 64 entries x 129 bits, 6-bit address.
- `nvdla_core_clk`  in  1  core clock; all state updates on the rising edge.
- `nvdla_core_rstn`  in  1  asynchronous, active-low reset.
- `cmd_pvld`  in  1  burst command valid.
- `cmd_prdy`  out  1  burst command ready.
- `cmd_addr`  in  6  first RAM address of the burst.
- `cmd_len`  in  6  beats minus one (0 → 1 beat, 63 → 64 beats).
- `ram_ra`  out  6  RAM read address.
- `ram_re`  out  1  RAM read-address latch enable.
- `ram_ore`  out  1  RAM output-register enable.
- `ram_dout`  in  129  RAM registered read data.
- `rsp_pvld`  out  1  response beat valid.
- `rsp_prdy`  in  1  response beat ready.
- `rsp_pd`  out  129  response data; equals `ram_dout`.
- `rsp_last`  out  1  marks the final beat of a burst; qualified by `rsp_pvld`.
- `rd_busy`  out  1  a burst is active or a beat is still in flight.

## Operation
- **Architecture:** a two-state FSM (IDLE, RUN) plus a 2-deep valid/last shadow pipeline that tracks the RAM's address register (stage 1) and output register (stage 2).
- **Registers:** `state`, `cur_addr[5:0]`, `rem[5:0]`, `v1`, `l1`, `v2`, `l2`.
- **IDLE:**
  - `cmd_prdy`=1.
  - On `cmd_pvld`&&`cmd_prdy`: `cur_addr`←`cmd_addr`, `rem`←`cmd_len`, go to RUN.
- **RUN:**
  - `cmd_prdy`=0.
  - Define `adv1` = !`v1` || `ram_ore`.
  - `ram_re` = RUN && `adv1`; `ram_ra` = `cur_addr`.
  - On `ram_re`: `v1`←1, `l1`←(`rem`==0), `cur_addr`←`cur_addr`+1 (mod 64, so 63 wraps to 0), `rem`←`rem`-1.
  - If `rem`==0 on that issue, go to IDLE.
- **Pipeline control:**
  - `ram_ore` = `v1` && (!`v2` || `rsp_prdy`).
  - On `ram_ore`: `v2`←1, `l2`←`l1`.
  - If `ram_ore` && !`ram_re`: `v1`←0.
  - If `v2` && `rsp_prdy` && !`ram_ore`: `v2`←0.
- **Response outputs:** `rsp_pvld`=`v2`, `rsp_last`=`l2`, `rsp_pd`=`ram_dout`.
- **Stall behaviour:** `ram_dout` holds while `ore`=0, so stalled beats stay stable with no skid buffer.
- **Busy:** `rd_busy` = RUN || `v1` || `v2`.
- **Bursts across the top of the array:** a burst with start+len > 63 wraps, e.g. addr 62, len 3 reads 62, 63, 0, 1.
- **Back-to-back commands:**
  - The next command is accepted only in IDLE.
  - A new command can be accepted the cycle after the last issue.
  - This leaves a one-cycle `ram_re` gap between bursts.
  - Earlier beats still draining in stages 1 and 2 do not block acceptance.
- **Reset:**
  - Asynchronous assertion forces IDLE; `cur_addr`, `rem`, `v1`, `l1`, `v2`, `l2` all go to 0.
  - Resulting outputs: `cmd_prdy`=1, `ram_re`=0, `ram_ore`=0, `rsp_pvld`=0, `rsp_last`=0, `rd_busy`=0, `ram_ra`=0.
  - Reset mid-burst drops all in-flight beats.
  - The RAM's internal registers are not reset; the valid bits guarantee no spurious `rsp_pvld`.

## Timing
- Cycle numbers below are counted from the command handshake cycle c0.
  - c1: `ram_re`=1, `ram_ra`=A.
  - c2: `ram_ore`=1 (when not stalled).
  - c3: `rsp_pvld`=1, `rsp_pd`=M[A].
- Fixed latency from `ram_re` to `rsp_pvld` is 2 cycles when `rsp_prdy`=1.
- Throughput is 1 beat/cycle while `rsp_prdy`=1. An N-beat burst with no stall puts its last beat on `rsp_pvld` in cycle c(N+2).
- `rsp_prdy`=0 with both stages full:
  - `ram_ore`=0 and `ram_re`=0 the same cycle.
  - The pipeline freezes; `rsp_pd` and `rsp_last` hold.
  - Resuming `rsp_prdy` restarts both stages in that cycle, with no bubble.
- `rsp_pvld` must not drop while waiting for `rsp_prdy`.
- `rsp_pd` must not change while `rsp_pvld` && !`rsp_prdy`.
- Data correctness: RAM writes to an address that land before its `ram_re` cycle are visible; later writes are not. This is RAM behaviour, not controlled here.

## Test plan
- **Reset state:** reset, then idle → `cmd_prdy`=1, `rd_busy`=0, and `ram_re`, `ram_ore`, `rsp_pvld` all 0.
- **Single beat:** preload M[5]=129'h1_0000…00AB; cmd addr=5, len=0 → `ram_re` at c1 with `ram_ra`=5; `rsp_pvld`&&`rsp_last` at c3 with data 129'h1_0000…00AB; `rd_busy` falls at c4.
- **Wrapping burst:** M[i]=i; cmd addr=62, len=3, `rsp_prdy`=1 → beats 62, 63, 0, 1 on c3–c6; `rsp_last` only on the beat carrying 1.
- **Backpressure:** M[i]=i; 64-beat burst from 0 with `rsp_prdy` toggled by an LFSR → all 64 values arrive in order, none duplicated or dropped, and held data is stable while stalled.
- **Back-to-back bursts:** cmd (10, len 1) then cmd (20, len 0) held valid → second handshake occurs the cycle after the first burst's last issue; responses are 10, 11(last), 20(last).
- **Mid-burst reset:** assert `nvdla_core_rstn`=0 in c4 of a 16-beat burst → `rsp_pvld`=0 immediately (asynchronously); after release, `cmd_prdy`=1 and no stale beats appear.
